perceptron_mac: RTL and testbench

//  Dot-product/activation stage downstream of the 64x16 weight memory and the matching input memory.
//  On start it sequences addr 0..len-1 into both memories and accumulates signed w*x products plus bias.
//  It then emits the Q6.9 neuron sum and a step-activation class bit.
//  All data is Q6.9 (value*512), signed two's complement.

---
 rtl/perceptron_mac.sv | 144 ++++++++++++++
 tb/tb_perceptron_mac.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_mac.sv
// Perceptron dot-product stage: streams len weight/input pairs, accumulates w*x plus bias, emits Q6.9 sum and class bit.
// Optional saturation of the Q6.9 result is enabled by defining ACC_SAT_EN.
module perceptron_mac #(
  parameter int N_IN = 64,
  parameter int DW   = 16,
  parameter int AW   = 7,
  parameter int FRAC = 9,
  parameter int ACCW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] bias,
  output logic          w_ena,
  output logic          w_wr_rd,
  output logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          x_ena,
  output logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] y_sum,
  output logic          y_class,
  output logic          sat
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [AW-1:0]        idx;
  logic [AW-1:0]        n_terms;
  logic [AW-1:0]        len_clamped;
  logic                 valid;
  logic signed [ACCW-1:0] acc;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] r;
  logic [DW-1:0]        y_next;
  logic                 sat_next;
  logic                 accept;

  assign len_clamped = (len > AW'(N_IN)) ? AW'(N_IN) : len;
  assign accept      = (state == IDLE) && start;

  assign prod     = $signed(w_data) * $signed(x_data);
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(ACCW-DW){bias[DW-1]}}, bias} <<< FRAC;
  assign r        = acc >>> FRAC;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len_clamped == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (idx == n_terms - AW'(1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN:   state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result formatting: overflow exists when the bits above the Q6.9 sign are not all copies of it.
`ifdef ACC_SAT_EN
  always_comb begin
    y_next   = r[DW-1:0];
    sat_next = 1'b0;
    if (!(&r[ACCW-1:DW-1]) && (|r[ACCW-1:DW-1])) begin
      sat_next = 1'b1;
      y_next   = r[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  always_comb begin
    y_next   = r[DW-1:0];
    sat_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      n_terms <= '0;
      valid   <= 1'b0;
      acc     <= '0;
    end else begin
      state <= state_next;
      valid <= (state == FETCH);
      if (accept) begin
        n_terms <= len_clamped;
        idx     <= '0;
        acc     <= bias_ext;
      end else begin
        if (state == FETCH) begin
          idx <= idx + AW'(1);
        end
        // Memory data arrives one cycle after each issued address.
        if (valid) begin
          acc <= acc + prod_ext;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      y_sum   <= '0;
      y_class <= 1'b0;
      sat     <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) begin
        y_sum   <= y_next;
        y_class <= ~acc[ACCW-1];
        sat     <= sat_next;
      end
    end
  end

  assign w_ena   = (state == FETCH);
  assign x_ena   = w_ena;
  assign w_addr  = w_ena ? idx : '0;
  assign x_addr  = w_addr;
  assign w_wr_rd = 1'b0;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_perceptron_mac.sv
// Bench for perceptron_mac: memory models, arithmetic reference model, directed and random evaluations.
module tb_perceptron_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic [15:0] bias = '0;
  logic        w_ena, w_wr_rd, x_ena, busy, done, y_class, sat;
  logic [6:0]  w_addr, x_addr;
  logic [15:0] w_data = '0;
  logic [15:0] x_data = '0;
  logic [15:0] y_sum;

  always #5 clk = ~clk;

  perceptron_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .w_ena(w_ena), .w_wr_rd(w_wr_rd), .w_addr(w_addr), .w_data(w_data),
    .x_ena(x_ena), .x_addr(x_addr), .x_data(x_data),
    .busy(busy), .done(done), .y_sum(y_sum), .y_class(y_class), .sat(sat)
  );

  logic signed [15:0] wmem [64];
  logic signed [15:0] xmem [64];
  int addr_hist [8192];
  int ena_total = 0;
  int link_bad = 0;

  // Synchronous-read memories plus a log of every issued address.
  always @(posedge clk) begin
    if (w_ena === 1'b1) begin
      w_data <= wmem[w_addr[5:0]];
      addr_hist[ena_total % 8192] <= int'(w_addr);
      ena_total <= ena_total + 1;
    end
    if (x_ena === 1'b1) x_data <= xmem[x_addr[5:0]];
    if (x_ena !== w_ena || (w_ena === 1'b1 && x_addr !== w_addr) || w_wr_rd !== 1'b0)
      link_bad <= link_bad + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [6:0] l, input logic [15:0] b,
                                output logic [15:0] y, output logic cls, output logic s,
                                output int n);
    longint acc;
    longint r;
    n = (l > 7'd64) ? 64 : int'(l);
    acc = longint'($signed(b)) * 512;
    for (int i = 0; i < n; i++) acc += longint'(wmem[i]) * longint'(xmem[i]);
    r = acc >>> 9;
    cls = (acc >= 0);
    y = 16'(r);
    s = 1'b0;
`ifdef ACC_SAT_EN
    if (r > 32767) begin y = 16'h7FFF; s = 1'b1; end
    else if (r < -32768) begin y = 16'h8000; s = 1'b1; end
`endif
  endfunction

  task automatic launch(input logic [6:0] l, input logic [15:0] b);
    len = l; bias = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    len = 7'($urandom);
    bias = 16'($urandom);
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin k = c; break; end
    end
  endtask

  task automatic check_result(input string tag, input int base, input int n,
                              input logic [15:0] ey, input logic ecls, input logic es);
    int first_bad;
    chk({tag, "_ysum"}, 64'(y_sum), 64'(ey));
    chk({tag, "_class"}, 64'(y_class), 64'(ecls));
    chk({tag, "_sat"}, 64'(sat), 64'(es));
    chk({tag, "_busy_done"}, 64'(busy), 64'(0));
    chk({tag, "_ena_count"}, 64'(ena_total - base), 64'(n));
    first_bad = -1;
    for (int i = 0; i < n; i++)
      if (addr_hist[(base + i) % 8192] != i && first_bad < 0) first_bad = i;
    chk({tag, "_addr_seq"}, 64'(first_bad), 64'(-1));
    chk({tag, "_link"}, 64'(link_bad), 64'(0));
  endtask

  task automatic run_eval(input string tag, input logic [6:0] l, input logic [15:0] b);
    logic [15:0] ey; logic ecls, es; int n, k, base;
    model(l, b, ey, ecls, es, n);
    base = ena_total;
    launch(l, b);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    wait_done(k);
    chk({tag, "_latency"}, 64'(k), 64'((n == 0) ? 1 : n + 2));
    check_result(tag, base, n, ey, ecls, es);
    $display("eval %s len=%0d bias=%h -> y_sum=%h class=%0b sat=%0b latency=%0d",
             tag, l, b, y_sum, y_class, sat, k);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      wmem[i] = 16'($urandom);
      xmem[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
    end
  endtask

  initial begin
    logic [15:0] ey; logic ecls, es; int n, k, base; logic saw_done;
    for (int i = 0; i < 64; i++) begin wmem[i] = '0; xmem[i] = '0; end

    #1;
    chk("rst_w_ena", 64'(w_ena), 64'(0));
    chk("rst_x_ena", 64'(x_ena), 64'(0));
    chk("rst_addr", 64'({w_addr, x_addr}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_outs", 64'({y_sum, y_class, sat}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: basic two-term dot product
    wmem[0] = 512; wmem[1] = 256; xmem[0] = 512; xmem[1] = 512;
    run_eval("t1", 7'd2, 16'd0);
    chk("t1_const", 64'(y_sum), 64'(768));
    @(posedge clk); #1;
    chk("t1_done_pulse", 64'(done), 64'(0));
    chk("t1_hold", 64'(y_sum), 64'(768));

    // 2: negative result with bias
    wmem[0] = -512; xmem[0] = 512;
    run_eval("t2", 7'd1, 16'd256);
    chk("t2_const", 64'(y_sum), 64'(16'hFF00));

    // 3: zero-length, bias only (started in the done cycle of t2)
    run_eval("t3", 7'd0, 16'hFFFF);
    chk("t3_const", 64'(y_sum), 64'(16'hFFFF));

    // 4: full length at maximum magnitude
    for (int i = 0; i < 64; i++) begin wmem[i] = 32767; xmem[i] = 32767; end
    run_eval("t4", 7'd64, 16'd0);
`ifdef ACC_SAT_EN
    chk("t4_const", 64'({y_sum, sat}), 64'({16'd32767, 1'b1}));
`else
    chk("t4_const", 64'({y_sum, sat}), 64'({16'hE000, 1'b0}));
`endif
    run_eval("t4_clamp", 7'd127, 16'h8000);

    // 5: floor rounding
    wmem[0] = 1; xmem[0] = 1;
    run_eval("t5a", 7'd1, 16'd0);
    chk("t5a_const", 64'(y_sum), 64'(0));
    wmem[0] = -1;
    run_eval("t5b", 7'd1, 16'd0);
    chk("t5b_const", 64'(y_sum), 64'(16'hFFFF));

    // 6a: start pulse during FETCH is ignored
    fill_random();
    model(7'd10, 16'h0123, ey, ecls, es, n);
    base = ena_total;
    launch(7'd10, 16'h0123);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; len = 7'd2; bias = 16'h4000;
    @(posedge clk); #1; start = 1'b0;
    wait_done(k);
    chk("t6_ign_latency", 64'(k + 4), 64'(12));
    check_result("t6_ign", base, n, ey, ecls, es);
    $display("eval t6_ign len=10 -> y_sum=%h class=%0b latency=%0d", y_sum, y_class, k + 4);

    // 6b: asynchronous reset mid-FETCH
    launch(7'd20, 16'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_ena", 64'({w_ena, x_ena}), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    chk("t6_rst_no_done", 64'(saw_done), 64'(0));
    chk("t6_rst_ysum", 64'(y_sum), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    $display("reset mid-FETCH applied, busy=%0b done_seen=%0b", busy, saw_done);
    for (int i = 0; i < 64; i++) begin wmem[i] = '0; xmem[i] = '0; end
    wmem[0] = 512; wmem[1] = 256; xmem[0] = 512; xmem[1] = 512;
    run_eval("t6_rerun", 7'd2, 16'd0);
    chk("t6_rerun_const", 64'(y_sum), 64'(768));

    // Random evaluations, back to back
    for (int t = 0; t < 10; t++) begin
      fill_random();
      run_eval($sformatf("rnd%0d", t), 7'($urandom_range(0, 127)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
